// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle RV32I controller FSM with memory handshake and wait timeout.
// Define MC_CTRL_BRANCH_EXT_EN for the full branch set; otherwise only BEQ is legal.
module multicycle_ctrl #(
    parameter int ALUCTRL_W  = 3,
    parameter int WAIT_LIMIT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic                 Zero,
    input  logic                 Neg,
    input  logic                 Ovf,
    input  logic                 Carry,
    input  logic                 MemReady,
    output logic                 MemReq,
    output logic                 MemWrite,
    output logic                 AdrSrc,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic                 RegWrite,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ImmSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 Illegal,
    output logic                 MemFault,
    output logic [3:0]           State
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP
    } st_t;
    typedef struct packed {
        logic                 req, wr, adr, pcw, rw;
        logic [1:0]           a, b, res;
        logic [ALUCTRL_W-1:0] ctl;
    } mo_t;
    localparam int CW = WAIT_LIMIT > 1 ? $clog2(WAIT_LIMIT) : 1;

    st_t state, nxt, ns;
    mo_t m, mn;
    logic [CW-1:0] cnt;
    logic ld, st, rt, it, br, jl, slt_bad, br_bad, memst, tmo, taken, unused;
    logic [ALUCTRL_W-1:0] fop;

    assign ld = opcode == 7'b0000011;
    assign st = opcode == 7'b0100011;
    assign rt = opcode == 7'b0110011;
    assign it = opcode == 7'b0010011;
    assign br = opcode == 7'b1100011;
    assign jl = opcode == 7'b1101111;
    assign slt_bad = ALUCTRL_W < 4 && funct3[2:1] == 2'b01;
`ifdef MC_CTRL_BRANCH_EXT_EN
    assign br_bad = funct3[2:1] == 2'b01;
    // funct3[0] inverts each base condition (BNE, BGE, BGEU)
    assign taken = funct3[2] ? (funct3[1] ? Carry ~^ funct3[0] : Neg ^ Ovf ^ funct3[0])
                             : Zero ^ funct3[0];
    assign unused = ^{funct7[6], funct7[4:0]};
`else
    assign br_bad = funct3 != 3'b000;
    assign taken = Zero;
    assign unused = ^{funct7[6], funct7[4:0], Neg, Ovf, Carry};
`endif

    always_comb begin
        case (funct3)
            3'b000:  fop = ALUCTRL_W'(rt && funct7[5]);
            3'b001:  fop = ALUCTRL_W'(2);
            3'b010:  fop = ALUCTRL_W'(8);
            3'b011:  fop = ALUCTRL_W'(9);
            3'b101:  fop = funct7[5] ? ALUCTRL_W'(3) : ALUCTRL_W'(5);
            default: fop = ALUCTRL_W'(funct3);
        endcase
    end

    assign memst = state == FETCH || state == MEMREAD || state == MEMWRITE;
    // Trap on the cycle the stall count would reach the limit, unless memory answers then
    assign tmo = WAIT_LIMIT != 0 && memst && !MemReady && cnt == CW'(WAIT_LIMIT - 1);

    always_comb begin
        nxt = state;
        case (state)
            FETCH:    nxt = MemReady ? DECODE : tmo ? TRAP : FETCH;
            DECODE:   nxt = ld || st ? MEMADR : rt && !slt_bad ? EXECR : it && !slt_bad ? EXECI
                          : br && !br_bad ? BRANCH : jl ? JAL : TRAP;
            MEMADR:   nxt = ld ? MEMREAD : MEMWRITE;
            MEMREAD:  nxt = MemReady ? MEMWB : tmo ? TRAP : MEMREAD;
            MEMWRITE: nxt = MemReady ? FETCH : tmo ? TRAP : MEMWRITE;
            EXECR, EXECI, JAL:    nxt = ALUWB;
            MEMWB, ALUWB, BRANCH: nxt = FETCH;
            default:  nxt = TRAP;
        endcase
    end

    assign ns = rst ? FETCH : nxt;

    // Moore outputs of the upcoming state, registered alongside it
    always_comb begin
        mn = '0;
        case (ns)
            FETCH:    begin mn.req = 1'b1; mn.b = 2'b10; mn.res = 2'b10; end
            DECODE:   begin mn.a = 2'b01; mn.b = 2'b01; end
            MEMADR:   begin mn.a = 2'b10; mn.b = 2'b01; end
            MEMREAD:  begin mn.req = 1'b1; mn.adr = 1'b1; end
            MEMWRITE: begin mn.req = 1'b1; mn.wr = 1'b1; mn.adr = 1'b1; end
            MEMWB:    begin mn.res = 2'b01; mn.rw = 1'b1; end
            EXECR:    begin mn.a = 2'b10; mn.ctl = fop; end
            EXECI:    begin mn.a = 2'b10; mn.b = 2'b01; mn.ctl = fop; end
            ALUWB:    mn.rw = 1'b1;
            BRANCH:   begin mn.a = 2'b10; mn.ctl = ALUCTRL_W'(1); end
            JAL:      begin mn.a = 2'b01; mn.b = 2'b10; mn.pcw = 1'b1; end
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        m <= mn;
        if (rst) begin
            state <= FETCH;
            cnt <= '0;
            Illegal <= 1'b0;
            MemFault <= 1'b0;
        end else begin
            state <= nxt;
            cnt <= nxt != state ? '0 : cnt + CW'(memst && !MemReady);
            if (nxt == TRAP && state != TRAP) begin
                Illegal <= state == DECODE;
                MemFault <= state != DECODE;
            end
        end
    end

    assign MemReq = m.req && !rst;
    assign MemWrite = m.wr && !rst;
    assign AdrSrc = m.adr;
    assign IRWrite = state == FETCH && MemReady && !rst;
    assign PCWrite = !rst && (m.pcw || (state == FETCH && MemReady) || (state == BRANCH && taken));
    assign RegWrite = m.rw && !rst;
    assign ALUSrcA = m.a;
    assign ALUSrcB = m.b;
    assign ResultSrc = m.res;
    assign ALUControl = m.ctl;
    assign ImmSrc = st ? 2'b01 : br ? 2'b10 : jl ? 2'b11 : 2'b00;
    assign State = state;
endmodule
